pps_meter: RTL and testbench
============================

Name: pps_meter

Overview:
Receive-side counterpart of the PPS generator. It takes an external 1 Hz (nominal) pulse input and synchronizes it into the i_clk domain. It measures the number of i_clk cycles between consecutive rising edges and declares lock after LOCK_COUNT consecutive in-window periods. It is used to check or discipline a local PPS source against a reference and drives a status LED.

Parameters:
CLOCK_RATE_HZ, 100, nominal i_clk cycles per PPS period
TOLERANCE, 4, allowed |period - CLOCK_RATE_HZ| in cycles; must be < CLOCK_RATE_HZ-2
LOCK_COUNT, 3, consecutive in-window periods required to assert lock (1..15)
CNT_W, $clog2(CLOCK_RATE_HZ+TOLERANCE+1), period counter/output width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_pps  in  1  asynchronous PPS input, any pulse width >= 1 i_clk high and >= 1 i_clk low
o_period  out  CNT_W  last measured period in i_clk cycles
o_period_stb  out  1  one-cycle strobe, o_period updated this cycle
o_locked  out  1  lock status
o_fault  out  1  sticky: lock was lost; cleared on re-lock
o_led  out  1  equals o_locked

Behaviour:
- Reset is asynchronous, active-low. All flops clear: sync chain, cnt, good_cnt, o_period=0, o_period_stb=0, o_locked=0, o_fault=0, state=IDLE. Reset mid-count discards all history.
- Sync: 2-flop synchronizer plus prev flop, all reset to 0. rise = sync2 & ~prev. i_pps first sampled high at edge E0 gives rise during the cycle after E1. Registered outputs update at E2.
- Count: cnt is held at 0 in IDLE. In ACQ and LOCKED, cnt <= cnt+1 each cycle. On rise, cnt <= 0 and the captured period P = cnt+1. Rises P cycles apart therefore yield period P.
- Window: MIN_P = CLOCK_RATE_HZ-TOLERANCE, MAX_P = CLOCK_RATE_HZ+TOLERANCE, inclusive. All compares are unsigned at CNT_W bits.
- Timeout: no rise while cnt == MAX_P-1 means timeout next edge. A rise in that same cycle gives P = MAX_P, which is valid and is not a timeout.
- States:
  - IDLE: rise -> ACQ, good_cnt=0, no strobe (first edge has no reference).
  - ACQ: rise -> strobe, o_period=P. If in window, good_cnt++; when good_cnt reaches LOCK_COUNT -> LOCKED, o_locked=1, o_fault=0. If out of window, good_cnt=0 and stay in ACQ. Timeout -> IDLE, no strobe.
  - LOCKED: in-window rise -> strobe, stay. Out-of-window rise -> strobe, ACQ, good_cnt=0, o_locked=0, o_fault=1. Timeout -> IDLE, o_locked=0, o_fault=1.
- o_period holds its value between strobes. o_period_stb is high for exactly one cycle per accepted rise.
- o_locked changes on the same edge as the strobe for the deciding rise. For a timeout, it changes on the timeout edge.
- A long high pulse counts as one rise. Glitches shorter than 1 cycle may be missed; no filtering is specified.

Decomposition:
- Shared package pps_pkg holds:
  - state encoding localparams (IDLE/ACQ/LOCKED)
  - MIN_P/MAX_P derivation, also used by pps2 test benches.
- One sub-module, pps_sync_edge, contains the 2FF synchronizer and rise detector, with ports i_clk, i_rst_n, i_async, o_rise.

Test Plan:
All scenarios use CLOCK_RATE_HZ=100, TOLERANCE=4, LOCK_COUNT=3.
1. Five pulses, 100 cycles apart -> no strobe on pulse 1; strobes with o_period=100 on pulses 2-5; o_locked=1 at the pulse-4 strobe; o_fault=0.
2. Periods 96 then 104 -> both strobed and counted good. Period 95 -> strobe with 95, good_cnt reset. Pulse spacing 105 -> timeout 104 cycles after the last rise, state IDLE, no strobe; the next pulse gives no strobe.
3. Locked, then one 90-cycle period -> strobe with 90, o_locked=0, o_fault=1. Three further 100-cycle periods -> o_locked=1, o_fault=0.
4. Locked, then pulse omitted -> o_locked=0, o_fault=1 at the timeout edge. The next pulse gives no strobe; the one after strobes 100 and counts as good 1.
5. i_rst_n pulled low 40 cycles into a locked period -> all outputs 0 immediately. After release, the first pulse gives no strobe.
6. Pulse held high for 50 cycles at 100-cycle spacing -> one strobe per pulse, o_period=100, lock after 4 pulses.

Source files
------------

// File: rtl/pps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pps_pkg
//  Description : Shared definitions for the PPS measurement blocks: state
//                encoding of the meter FSM and the acceptance-window helpers
//                (MIN_P / MAX_P) used by the RTL and by its test benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package pps_pkg;

    // Meter FSM state encoding
    localparam logic [1:0] PPS_IDLE   = 2'd0;
    localparam logic [1:0] PPS_ACQ    = 2'd1;
    localparam logic [1:0] PPS_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = PPS_IDLE,
        ST_ACQ    = PPS_ACQ,
        ST_LOCKED = PPS_LOCKED
    } pps_state_e;

    // Shortest period (inclusive) accepted as in-window
    function automatic int pps_min_p(input int rate_hz, input int tol);
        return rate_hz - tol;
    endfunction

    // Longest period (inclusive) accepted as in-window; one cycle beyond
    // this without a rise is a timeout
    function automatic int pps_max_p(input int rate_hz, input int tol);
        return rate_hz + tol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pps_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : pps_sync_edge
//  Description : Two-flop synchronizer for an asynchronous pulse input plus a
//                rising-edge detector in the destination clock domain.
//  Ports       : i_clk   - destination clock
//                i_rst_n - asynchronous active-low reset
//                i_async - asynchronous input
//                o_rise  - high for one cycle per synchronized rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module pps_sync_edge
    import pps_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = i_async;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Combinational so the rise is visible in the cycle after the second
    // synchronizer stage captures the high level.
    assign o_rise = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/pps_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pps_meter
//  Description : Measures the i_clk period between rising edges of an external
//                PPS input and declares lock after LOCK_COUNT consecutive
//                in-window periods. Lock loss is flagged by a sticky fault.
//  Ports       : i_clk        - system clock
//                i_rst_n      - asynchronous active-low reset
//                i_pps        - asynchronous PPS input
//                o_period     - last measured period (i_clk cycles)
//                o_period_stb - one-cycle strobe when o_period updates
//                o_locked     - lock status
//                o_fault      - sticky lock-lost flag, cleared on re-lock
//                o_led        - status LED, mirrors o_locked
//  Revision    : 1.0 - initial release
// ============================================================================
module pps_meter
    import pps_pkg::*;
#(
    parameter int CLOCK_RATE_HZ = 100,
    parameter int TOLERANCE     = 4,
    parameter int LOCK_COUNT    = 3,
    parameter int CNT_W         = $clog2(CLOCK_RATE_HZ + TOLERANCE + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pps,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_stb,
    output logic             o_locked,
    output logic             o_fault,
    output logic             o_led
);

    localparam logic [CNT_W-1:0] c_min_p    = CNT_W'(pps_min_p(CLOCK_RATE_HZ, TOLERANCE));
    localparam logic [CNT_W-1:0] c_max_p    = CNT_W'(pps_max_p(CLOCK_RATE_HZ, TOLERANCE));
    localparam logic [CNT_W-1:0] c_max_m1   = CNT_W'(pps_max_p(CLOCK_RATE_HZ, TOLERANCE) - 1);
    localparam logic [3:0]       c_lock_cnt = 4'(LOCK_COUNT);

    logic w_rise;

    pps_sync_edge u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_pps),
        .o_rise  (w_rise)
    );

    pps_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [3:0]       good_q,   good_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             stb_q,    stb_d;
    logic             locked_q, locked_d;
    logic             fault_q,  fault_d;

    logic [CNT_W-1:0] w_p;
    logic             w_in_win;
    logic             w_timeout;
    logic [3:0]       w_good_inc;

    always_comb begin
        // Period ends on the rise cycle, so it is one more than the count
        w_p        = cnt_q + 1'b1;
        w_in_win   = (w_p >= c_min_p) && (w_p <= c_max_p);
        // A rise on the last legal cycle yields P = MAX_P, not a timeout
        w_timeout  = !w_rise && (cnt_q == c_max_m1);
        w_good_inc = good_q + 4'd1;

        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        good_d   = good_q;
        period_d = period_q;
        stb_d    = 1'b0;
        locked_d = locked_q;
        fault_d  = fault_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // First edge only establishes the reference point
                if (w_rise) begin
                    state_d = ST_ACQ;
                    good_d  = 4'd0;
                end
            end
            ST_ACQ: begin
                if (w_rise) begin
                    cnt_d    = '0;
                    stb_d    = 1'b1;
                    period_d = w_p;
                    if (w_in_win) begin
                        good_d = w_good_inc;
                        if (w_good_inc == c_lock_cnt) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            fault_d  = 1'b0;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (w_rise) begin
                    cnt_d    = '0;
                    stb_d    = 1'b1;
                    period_d = w_p;
                    if (!w_in_win) begin
                        state_d  = ST_ACQ;
                        good_d   = 4'd0;
                        locked_d = 1'b0;
                        fault_d  = 1'b1;
                    end
                end else if (w_timeout) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                    fault_d  = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            good_q   <= 4'd0;
            period_q <= '0;
            stb_q    <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            stb_q    <= stb_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
        end
    end

    assign o_period     = period_q;
    assign o_period_stb = stb_q;
    assign o_locked     = locked_q;
    assign o_fault      = fault_q;
    assign o_led        = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_pps_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pps_meter
//  Description : Self-checking bench for pps_meter. A period-level model
//                predicts each strobe (period, lock, fault) when a pulse is
//                driven; the monitor compares strobes against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pps_meter;
    import pps_pkg::*;

    localparam int CLOCK_RATE_HZ = 100;
    localparam int TOLERANCE     = 4;
    localparam int LOCK_COUNT    = 3;
    localparam int CNT_W         = $clog2(CLOCK_RATE_HZ + TOLERANCE + 1);
    localparam int MIN_P         = pps_min_p(CLOCK_RATE_HZ, TOLERANCE);
    localparam int MAX_P         = pps_max_p(CLOCK_RATE_HZ, TOLERANCE);

    logic             clk;
    logic             i_rst_n;
    logic             i_pps;
    logic [CNT_W-1:0] o_period;
    logic             o_period_stb;
    logic             o_locked;
    logic             o_fault;
    logic             o_led;

    pps_meter #(
        .CLOCK_RATE_HZ (CLOCK_RATE_HZ),
        .TOLERANCE     (TOLERANCE),
        .LOCK_COUNT    (LOCK_COUNT),
        .CNT_W         (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_pps        (i_pps),
        .o_period     (o_period),
        .o_period_stb (o_period_stb),
        .o_locked     (o_locked),
        .o_fault      (o_fault),
        .o_led        (o_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int period;
        bit locked;
        bit fault;
    } exp_t;

    exp_t sb_q[$];

    // Period-level reference model: 0 IDLE, 1 ACQ, 2 LOCKED
    int m_state;
    int m_good;
    bit m_locked;
    bit m_fault;
    int m_gap;

    function automatic void model_reset();
        m_state  = 0;
        m_good   = 0;
        m_locked = 0;
        m_fault  = 0;
        m_gap    = 100000;
    endfunction

    function automatic void model_timeout();
        if (m_state == 2) begin
            m_locked = 0;
            m_fault  = 1;
        end
        m_state = 0;
    endfunction

    function automatic void model_rise(input int g);
        bit   in_win;
        exp_t e;
        in_win = (g >= MIN_P) && (g <= MAX_P);
        if (m_state == 0) begin
            m_state = 1;
            m_good  = 0;
        end else begin
            if (m_state == 1) begin
                if (in_win) begin
                    m_good++;
                    if (m_good == LOCK_COUNT) begin
                        m_state  = 2;
                        m_locked = 1;
                        m_fault  = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end else if (!in_win) begin
                m_state  = 1;
                m_good   = 0;
                m_locked = 0;
                m_fault  = 1;
            end
            e.period = g;
            e.locked = m_locked;
            e.fault  = m_fault;
            sb_q.push_back(e);
        end
    endfunction

    // Drive one pulse of 'width' cycles, then idle until the next pulse
    // 'after' cycles from this rise.
    task automatic pps_pulse(input int width, input int after);
        model_rise(m_gap);
        i_pps = 1'b1;
        repeat (width) @(negedge clk);
        i_pps = 1'b0;
        if (after > MAX_P && m_state != 0) begin
            if (after >= 110) begin
                repeat (100 - width) @(negedge clk);
                chk("pre_timeout_locked", int'(o_locked), int'(m_locked));
                chk("pre_timeout_fault",  int'(o_fault),  int'(m_fault));
                repeat (8) @(negedge clk);
                model_timeout();
                chk("timeout_locked", int'(o_locked), int'(m_locked));
                chk("timeout_fault",  int'(o_fault),  int'(m_fault));
                chk("timeout_led",    int'(o_led),    int'(m_locked));
                repeat (after - 108) @(negedge clk);
            end else begin
                repeat (after - width) @(negedge clk);
                model_timeout();
            end
        end else begin
            repeat (after - width) @(negedge clk);
        end
        m_gap = after;
    endtask

    // Strobe monitor: every strobe must match the oldest prediction
    always @(negedge clk) begin
        if (i_rst_n && o_period_stb) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", int'(o_period_stb), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("period", int'(o_period), e.period);
                chk("locked", int'(o_locked), int'(e.locked));
                chk("fault",  int'(o_fault),  int'(e.fault));
                chk("led",    int'(o_led),    int'(e.locked));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        i_pps   = 1'b0;
        i_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", int'(o_period),     0);
        chk("rst_stb",    int'(o_period_stb), 0);
        chk("rst_locked", int'(o_locked),     0);
        chk("rst_fault",  int'(o_fault),      0);
        i_rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal pulses: lock on the fourth
        repeat (5) pps_pulse(1, 100);
        // Short period breaks lock, then three good periods re-lock
        pps_pulse(1, 90);
        repeat (3) pps_pulse(1, 100);
        // Omitted pulse -> timeout from LOCKED
        pps_pulse(1, 200);
        repeat (4) pps_pulse(1, 100);
        // Reset 40 cycles into a locked period
        pps_pulse(1, 40);
        i_rst_n = 1'b0;
        #1;
        chk("arst_period", int'(o_period),     0);
        chk("arst_stb",    int'(o_period_stb), 0);
        chk("arst_locked", int'(o_locked),     0);
        chk("arst_fault",  int'(o_fault),      0);
        chk("arst_led",    int'(o_led),        0);
        sb_q.delete();
        model_reset();
        repeat (5) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Window boundaries and timeout from ACQ
        pps_pulse(1, 96);
        pps_pulse(1, 104);
        pps_pulse(1, 95);
        pps_pulse(1, 105);
        pps_pulse(1, 100);
        // Long high pulses
        repeat (5) pps_pulse(50, 100);
        pps_pulse(1, 20);
        repeat (10) @(negedge clk);

        chk("pending_predictions", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
